sevenseg_scan: RTL

- Consumer end of the digit interface produced by the timekeeping counters (hour, minute and second BCD digits, plus the AM/PM code).
- Latches a coherent frame of NDIG 4-bit digit codes and time-multiplexes them onto a common-anode seven-segment display.
- Drives active-low anodes, segments and decimal point, with programmable refresh rate and an anti-ghosting blank interval at the start of each digit slot.
- Sits at the top level between the clock datapath and the board display pins.

---
 rtl/sevenseg_scan.sv | 88 ++++++++
 1 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: frame-latched, time-multiplexed common-anode seven-segment driver with per-slot blanking
module sevenseg_scan #(
  parameter int NDIG = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*NDIG-1:0]   din,
  input  logic [NDIG-1:0]     dp_mask,
  input  logic                lzb_en,
  output logic [NDIG-1:0]     an_n,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic                frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NDIG-1:0] din_q, din_d;
  logic [NDIG-1:0] dpm_q, dpm_d, an_q, an_d;
  logic lzb_q, lzb_d, dp_q, dp_d, ft_q, ft_d;
  logic [6:0] seg_q, seg_d, dec;
  logic wrap, last, frame, blank, lz;
  logic [3:0] dig;
  always_comb begin
    wrap = cnt_q == CW'(REFRESH_DIV - 1);
    last = idx_q == IW'(NDIG - 1);
    frame = wrap && last;
    blank = int'(cnt_q) < BLANK_CYC;
    dig = din_q[4*idx_q +: 4];
    lz = lzb_q && last && dig == 4'd0;
    dec = 7'h7F;
    case (dig)
      4'd0:  dec = 7'b1000000;
      4'd1:  dec = 7'b1111001;
      4'd2:  dec = 7'b0100100;
      4'd3:  dec = 7'b0110000;
      4'd4:  dec = 7'b0011001;
      4'd5:  dec = 7'b0010010;
      4'd6:  dec = 7'b0000010;
      4'd7:  dec = 7'b1111000;
      4'd8:  dec = 7'b0000000;
      4'd9:  dec = 7'b0010000;
      4'd10: dec = 7'b0001000;
      4'd11: dec = 7'b0001100;
      4'd12: dec = 7'b0111111;
      default: dec = 7'h7F;
    endcase
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = frame ? '0 : wrap ? idx_q + 1'b1 : idx_q;
    din_d = frame ? din : din_q;
    dpm_d = frame ? dp_mask : dpm_q;
    lzb_d = frame ? lzb_en : lzb_q;
    ft_d = frame;
    an_d = blank ? '1 : ~(NDIG'(1) << idx_q);
    seg_d = blank || lz ? 7'h7F : dec;
    dp_d = blank ? 1'b1 : ~dpm_q[idx_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      din_q <= din;
      dpm_q <= dp_mask;
      lzb_q <= lzb_en;
      ft_q <= 1'b0;
      an_q <= '1;
      seg_q <= 7'h7F;
      dp_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      din_q <= din_d;
      dpm_q <= dpm_d;
      lzb_q <= lzb_d;
      ft_q <= ft_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign an_n = an_q;
  assign seg_n = seg_q;
  assign dp_n = dp_q;
  assign frame_tick = ft_q;
endmodule
